// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game blocks.
package genius_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        BLUE   = 2'd3
    } color_t;

    localparam int DONE_BIT        = 5;
    localparam int PASS_BIT        = 4;
    localparam int MAX_LEN_DEFAULT = 16;

    // One-hot LED/button pattern for a color code (bit 0 green ... bit 3 blue).
    function automatic logic [3:0] color_to_onehot(input color_t color);
        return 4'b0001 << color;
    endfunction

    // Status word reported to the FSM once an evaluation has finished.
    function automatic logic [5:0] make_status(input logic pass, input logic [3:0] index);
        logic [5:0] status;
        status           = '0;
        status[DONE_BIT] = 1'b1;
        status[PASS_BIT] = pass;
        status[3:0]      = index;
        return status;
    endfunction

endpackage

// File: rtl/button_encoder.sv
// Combinational one-hot button to color encoder.
// Flags an idle bus (none) and illegal multi-button chords (multi); the
// color output is only meaningful when both flags are low.
module button_encoder
    import genius_pkg::*;
(
    input  logic [3:0] buttons,
    output color_t     color,
    output logic       none,
    output logic       multi
);

    // Decode the button bus into a color code plus idle/chord flags.
    always_comb begin
        color = GREEN;
        none  = 1'b0;
        multi = 1'b0;
        case (buttons)
            4'b0000: none  = 1'b1;
            4'b0001: color = GREEN;
            4'b0010: color = YELLOW;
            4'b0100: color = RED;
            4'b1000: color = BLUE;
            default: multi = 1'b1;
        endcase
    end

endmodule

// File: rtl/evaluation_module.sv
// Evaluation sub-module of the Genius game FSM.
// Captures one button press per sequence element, compares it against the
// latched color sequence and reports done/pass/index on o_value.
// Optional build macro EVAL_TIMEOUT_EN adds a per-press inactivity timeout
// (TIMEOUT_CYCLES); without it the module waits for the player indefinitely.
module evaluation_module
    import genius_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT
`ifdef EVAL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
`endif
) (
    input  logic                       i_clk,
    input  logic                       i_reset_button,
    input  logic                       i_enable,
    input  logic [2*MAX_LEN-1:0]       i_sequence,
    input  logic [$clog2(MAX_LEN):0]   i_length,
    input  logic [3:0]                 i_play_button,
    output logic [5:0]                 o_value,
    output logic [3:0]                 o_led_color
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_RELEASE,
        S_LISTEN,
        S_HOLD,
        S_DONE
    } eval_state_t;

    eval_state_t          state;
    logic [2*MAX_LEN-1:0] seq_q;
    logic [LW-1:0]        length_q;
    logic [IW-1:0]        index;
    color_t               color_q;

    color_t               pressed_color;
    logic                 buttons_none;
    logic                 buttons_multi;
    color_t               expected_color;
    logic                 is_last;
    logic [LW-1:0]        clamped_length;
    logic                 timed_out;

    button_encoder u_button_encoder (
        .buttons (i_play_button),
        .color   (pressed_color),
        .none    (buttons_none),
        .multi   (buttons_multi)
    );

    assign expected_color = color_t'(seq_q[2*index +: 2]);
    assign is_last        = ({1'b0, index} == (length_q - LW'(1)));
    assign clamped_length = (i_length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : i_length;

`ifdef EVAL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] timer;
    logic          timer_active;

    assign timer_active = (state == S_RELEASE) || (state == S_LISTEN) || (state == S_HOLD);
    assign timed_out    = timer_active && (timer == TW'(TIMEOUT_CYCLES - 1));

    // Inactivity timer; restarts whenever the player gets a fresh chance to press.
    always_ff @(posedge i_clk) begin
        if (i_reset_button || !i_enable) begin
            timer <= '0;
        end else if (((state == S_RELEASE) || (state == S_HOLD)) && buttons_none) begin
            timer <= '0;
        end else if (timer_active) begin
            timer <= timer + TW'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Evaluation FSM with registered status and LED outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset_button) begin
            state       <= S_OFF;
            o_value     <= '0;
            o_led_color <= '0;
            index       <= '0;
            seq_q       <= '0;
            length_q    <= '0;
            color_q     <= GREEN;
        end else if (!i_enable) begin
            state       <= S_OFF;
            o_value     <= '0;
            o_led_color <= '0;
            index       <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    seq_q    <= i_sequence;
                    length_q <= clamped_length;
                    index    <= '0;
                    if (i_length == '0) begin
                        state   <= S_DONE;
                        o_value <= make_status(1'b1, 4'd0);
                    end else begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (timed_out) begin
                        state   <= S_DONE;
                        o_value <= make_status(1'b0, 4'(index));
                    end else if (buttons_none) begin
                        state <= S_LISTEN;
                    end
                end
                S_LISTEN: begin
                    if (timed_out) begin
                        state   <= S_DONE;
                        o_value <= make_status(1'b0, 4'(index));
                    end else if (buttons_multi) begin
                        state   <= S_DONE;
                        o_value <= make_status(1'b0, 4'(index));
                    end else if (!buttons_none) begin
                        color_q     <= pressed_color;
                        o_led_color <= color_to_onehot(pressed_color);
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (timed_out) begin
                        state       <= S_DONE;
                        o_value     <= make_status(1'b0, 4'(index));
                        o_led_color <= '0;
                    end else if (buttons_none) begin
                        o_led_color <= '0;
                        if (color_q != expected_color) begin
                            state   <= S_DONE;
                            o_value <= make_status(1'b0, 4'(index));
                        end else if (is_last) begin
                            state   <= S_DONE;
                            o_value <= make_status(1'b1, 4'(index));
                        end else begin
                            index <= index + IW'(1);
                            state <= S_LISTEN;
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evaluation_module.sv
// Self-checking bench for evaluation_module: a cycle-by-cycle vector table
// for a full matching game plus hand-written multi-cycle corner cases.
module tb_evaluation_module;

    logic        i_clk = 1'b0;
    logic        i_reset_button;
    logic        i_enable;
    logic [31:0] i_sequence;
    logic [4:0]  i_length;
    logic [3:0]  i_play_button;
    logic [5:0]  o_value;
    logic [3:0]  o_led_color;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       en;
        logic [3:0] btn;
        logic [5:0] exp_value;
        logic [3:0] exp_led;
    } vec_t;

    vec_t vecs [20];

    localparam logic [31:0] SEQ_GYRB = 32'h0000_00E4;
    localparam logic [31:0] SEQ_RRG  = 32'h0000_000A;

    evaluation_module #(
        .MAX_LEN(16)
`ifdef EVAL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(50)
`endif
    ) dut (
        .i_clk          (i_clk),
        .i_reset_button (i_reset_button),
        .i_enable       (i_enable),
        .i_sequence     (i_sequence),
        .i_length       (i_length),
        .i_play_button  (i_play_button),
        .o_value        (o_value),
        .o_led_color    (o_led_color)
    );

    // 200 MHz system clock.
    always #2.5 i_clk = ~i_clk;

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic applyStimulus(input logic en, input logic [3:0] btn);
        i_enable      = en;
        i_play_button = btn;
        @(posedge i_clk);
        #1;
    endtask

    // Compare both outputs against the expected pair.
    task automatic checkOutput(input string name, input logic [5:0] exp_value, input logic [3:0] exp_led);
        total++;
        if (o_value !== exp_value || o_led_color !== exp_led) begin
            bad++;
            $display("[TB] FAIL %s: got value=%b led=%b, want value=%b led=%b",
                     name, o_value, o_led_color, exp_value, exp_led);
        end
    endtask

    // One press held for hold cycles followed by a one-cycle release.
    task automatic pressElement(input logic [3:0] btn, input int hold);
        repeat (hold) applyStimulus(1'b1, btn);
        applyStimulus(1'b1, 4'b0000);
    endtask

    // Correct play of the green/yellow/red/blue sequence.
    task automatic playGyrb();
        pressElement(4'b0001, 1);
        pressElement(4'b0010, 1);
        pressElement(4'b0100, 1);
        pressElement(4'b1000, 1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b0000, 6'h00, 4'h0};
        vecs[1]  = '{1'b1, 4'b0000, 6'h00, 4'h0};
        vecs[2]  = '{1'b1, 4'b0001, 6'h00, 4'h1};
        vecs[3]  = '{1'b1, 4'b0001, 6'h00, 4'h1};
        vecs[4]  = '{1'b1, 4'b0001, 6'h00, 4'h1};
        vecs[5]  = '{1'b1, 4'b0000, 6'h00, 4'h0};
        vecs[6]  = '{1'b1, 4'b0010, 6'h00, 4'h2};
        vecs[7]  = '{1'b1, 4'b0010, 6'h00, 4'h2};
        vecs[8]  = '{1'b1, 4'b0010, 6'h00, 4'h2};
        vecs[9]  = '{1'b1, 4'b0000, 6'h00, 4'h0};
        vecs[10] = '{1'b1, 4'b0100, 6'h00, 4'h4};
        vecs[11] = '{1'b1, 4'b0100, 6'h00, 4'h4};
        vecs[12] = '{1'b1, 4'b0100, 6'h00, 4'h4};
        vecs[13] = '{1'b1, 4'b0000, 6'h00, 4'h0};
        vecs[14] = '{1'b1, 4'b1000, 6'h00, 4'h8};
        vecs[15] = '{1'b1, 4'b1000, 6'h00, 4'h8};
        vecs[16] = '{1'b1, 4'b1000, 6'h00, 4'h8};
        vecs[17] = '{1'b1, 4'b0000, 6'h33, 4'h0};
        vecs[18] = '{1'b1, 4'b0000, 6'h33, 4'h0};
        vecs[19] = '{1'b0, 4'b0000, 6'h00, 4'h0};

        i_reset_button = 1'b1;
        i_enable       = 1'b0;
        i_sequence     = SEQ_GYRB;
        i_length       = 5'd4;
        i_play_button  = 4'b0000;
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        checkOutput("reset_state", 6'h00, 4'h0);
        i_reset_button = 1'b0;
        applyStimulus(1'b0, 4'b0000);

        $display("[TB] matching sequence table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].en, vecs[i].btn);
            checkOutput($sformatf("match_vec%0d", i), vecs[i].exp_value, vecs[i].exp_led);
        end

        $display("[TB] wrong color");
        i_sequence = SEQ_RRG;
        i_length   = 5'd3;
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        pressElement(4'b0100, 1);
        applyStimulus(1'b1, 4'b1000);
        checkOutput("error_hold_led", 6'h00, 4'h8);
        applyStimulus(1'b1, 4'b0000);
        checkOutput("error_done", 6'h21, 4'h0);
        pressElement(4'b0001, 2);
        checkOutput("error_stable", 6'h21, 4'h0);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("error_disable", 6'h00, 4'h0);

        $display("[TB] held start press and chord");
        i_sequence = SEQ_GYRB;
        i_length   = 5'd4;
        repeat (4) applyStimulus(1'b1, 4'b0001);
        checkOutput("held_start_ignored", 6'h00, 4'h0);
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0101);
        checkOutput("chord_fail", 6'h20, 4'h0);
        applyStimulus(1'b0, 4'b0000);

        $display("[TB] abort and restart");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        pressElement(4'b0001, 1);
        pressElement(4'b0010, 1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("abort_clear", 6'h00, 4'h0);
        applyStimulus(1'b1, 4'b0000);
        i_sequence = 32'hFFFF_FFFF;
        applyStimulus(1'b1, 4'b0000);
        playGyrb();
        checkOutput("restart_pass", 6'h33, 4'h0);
        applyStimulus(1'b0, 4'b0000);
        i_sequence = SEQ_GYRB;

        $display("[TB] reset during hold");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0001);
        checkOutput("hold_before_reset", 6'h00, 4'h1);
        i_reset_button = 1'b1;
        applyStimulus(1'b1, 4'b0001);
        checkOutput("reset_in_hold", 6'h00, 4'h0);
        i_reset_button = 1'b0;
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        playGyrb();
        checkOutput("relatch_pass", 6'h33, 4'h0);
        applyStimulus(1'b0, 4'b0000);

        $display("[TB] zero length");
        i_length = 5'd0;
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        checkOutput("zero_length", 6'h30, 4'h0);
        applyStimulus(1'b0, 4'b0000);

        $display("[TB] length clamp");
        i_sequence = 32'h0000_0000;
        i_length   = 5'd20;
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        for (int k = 0; k < 15; k++) pressElement(4'b0001, 1);
        checkOutput("clamp_not_done", 6'h00, 4'h0);
        pressElement(4'b0001, 1);
        checkOutput("clamp_done", 6'h3F, 4'h0);
        applyStimulus(1'b0, 4'b0000);

        $display("[TB] idle player");
        i_sequence = SEQ_GYRB;
        i_length   = 5'd4;
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        pressElement(4'b0001, 1);
`ifdef EVAL_TIMEOUT_EN
        begin
            int cycles = 0;
            while (o_value[5] !== 1'b1 && cycles < 200) begin
                applyStimulus(1'b1, 4'b0000);
                cycles++;
            end
            checkOutput("timeout_value", 6'h21, 4'h0);
            total++;
            if (cycles != 50) begin
                bad++;
                $display("[TB] FAIL timeout_latency: got %0d cycles, want 50", cycles);
            end
        end
`else
        begin
            logic seen_done = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                applyStimulus(1'b1, 4'b0000);
                if (o_value[5] === 1'b1) seen_done = 1'b1;
            end
            total++;
            if (seen_done) begin
                bad++;
                $display("[TB] FAIL no_timeout: got done=1 during idle wait, want done=0");
            end
            checkOutput("no_timeout_value", 6'h00, 4'h0);
        end
`endif
        applyStimulus(1'b0, 4'b0000);
        checkOutput("final_off", 6'h00, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/evaluation_module.md
Name: evaluation_module

Overview:
- Responder on the FSM's enable/done sub-module handshake; serves the S_EVALUATION state.
- While enabled, it captures the player's button presses one per element and compares each to the stored color sequence.
- It returns a 6-bit status word: done, pass/fail and element index. The FSM consumes bit 5 to advance to S_SCOREBOARD.
- Also echoes the accepted press on the LED bus for player feedback.

Parameters:
- MAX_LEN, 16: maximum sequence length; the sequence bus is 2*MAX_LEN bits, 2 bits per element.
- TIMEOUT_CYCLES, 1_000_000_000: per-press inactivity limit in i_clk cycles (5 s at 200 MHz). Used only with EVAL_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock, 200 MHz, posedge.
- i_reset_button  in  1  reset; synchronous, active-high.
- i_enable  in  1  module enable from the FSM; high for the whole evaluation phase.
- i_sequence  in  2*MAX_LEN  color sequence; element k is at [2k+1:2k]. Codes: 0 green, 1 yellow, 2 red, 3 blue.
- i_length  in  $clog2(MAX_LEN)+1  number of valid elements, 0..MAX_LEN.
- i_play_button  in  4  debounced, active-high buttons. Bit 0 green, 1 yellow, 2 red, 3 blue.
- o_value  out  6  [5] done, [4] pass, [3:0] index of the last evaluated element.
- o_led_color  out  4  one-hot echo of the button currently accepted; 0 otherwise.

Behaviour:
- Reset (synchronous, i_reset_button=1 at posedge): state S_OFF, o_value=0, o_led_color=0, index=0, timer=0. Reset has priority over everything else.
- States: S_OFF, S_RELEASE, S_LISTEN, S_HOLD, S_DONE.
- S_OFF: outputs 0.
  - On i_enable=1: latch i_sequence and i_length. Go to S_DONE with pass=1 if length=0, else go to S_RELEASE.
- S_RELEASE: wait until i_play_button==0, so a held start press is not counted. Then go to S_LISTEN and clear the timer.
- S_LISTEN:
  - If exactly one bit is set: decode it to a 2-bit code, drive o_led_color with that one-hot value, and go to S_HOLD.
  - If more than one bit is set: fail immediately. Go to S_DONE with pass=0 and index=current.
- S_HOLD:
  - Keep o_led_color while the button is held; extra buttons during the hold are ignored.
  - On release (i_play_button==0), compare the code with element[index]:
    - mismatch: go to S_DONE with pass=0 and o_value[3:0]=index.
    - match with index==length-1: go to S_DONE with pass=1 and o_value[3:0]=index.
    - match otherwise: index+1, go to S_LISTEN.
  - o_led_color returns to 0 on release.
- S_DONE: o_value[5]=1 and o_value[4:0] are held stable for as long as i_enable=1.
- i_enable=0 in any state: go to S_OFF next cycle and clear all outputs. This covers an abort mid-sequence and the FSM's forced idle when start drops. A new enable always restarts at index 0.
- Latency: done asserts the cycle after the final release is sampled. The FSM sees o_value[5] one cycle after that.
- Index arithmetic: the counter is $clog2(MAX_LEN) bits and never wraps, because length-1 ends the sequence first. i_length>MAX_LEN is clamped to MAX_LEN at latch time.
- Inputs are sampled on posedge only. Sequence and length changes after latching are ignored.

Optional Feature:
- Macro: EVAL_TIMEOUT_EN.
- Defined:
  - A timer counts in S_RELEASE, S_LISTEN and S_HOLD, and restarts on each transition into S_LISTEN.
  - On reaching TIMEOUT_CYCLES-1: go to S_DONE with pass=0, o_value[3:0]=index.
- Undefined:
  - No timer logic is built; the module waits indefinitely.
  - Ports and all other behaviour are identical.

Decomposition:
- Shared package genius_pkg holds:
  - the color_t enum (GREEN=0, YELLOW=1, RED=2, BLUE=3);
  - the bit positions of the status word (DONE_BIT=5, PASS_BIT=4);
  - MAX_LEN_DEFAULT.
- The eval_state_t enum is local to the module.
- One natural sub-module, button_encoder: combinational one-hot-to-color_t encoder with a "multiple/none" flag. The display block reuses it.

Test Plan:
- Matching sequence: sequence elements {G,Y,R,B}, length=4, press in that order with 3-cycle holds -> LED echoes 0001, 0010, 0100, 1000; then o_value=6'b11_0011.
- Error: length=3, elements {R,R,G}, press R then B -> o_value=6'b10_0001 after the B release; the index does not advance further.
- Held start press and simultaneous presses: button 0 held high at enable -> no evaluation until released. Then 4'b0101 pressed in S_LISTEN -> o_value=6'b10_0000.
- Abort and restart: drop i_enable after 2 correct presses -> o_value=0 next cycle. Re-enable and press all elements correctly -> full pass, proving the index restarted at 0.
- Reset: assert i_reset_button in S_HOLD with i_enable still high -> o_value=0 and o_led_color=0 at the next edge, then the module re-latches from S_OFF. Separately, length=0 -> o_value=6'b11_0000 two cycles after enable.
- Timeout (EVAL_TIMEOUT_EN, TIMEOUT_CYCLES=50): no press after 1 correct press -> o_value=6'b10_0001 at cycle 50. With the macro undefined, the same stimulus stays not-done for at least 1000 cycles.
